reset_requester: RTL

RESET_REQUESTER -- requirements
Module: reset_requester

---
 rtl/reset_requester_pkg.sv | 32 +++
 rtl/reset_requester_req_debounce.sv | 52 +++++
 rtl/reset_requester.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reset_requester_pkg.sv
// ============================================================================
// Module      : reset_requester_pkg
// Description : Shared state encoding, default parameters and counter widths
//               for the reset requester and its clock/reset generator bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_requester_pkg;

  localparam int c_DEF_DEBOUNCE_CYCLES = 4;
  localparam int c_DEF_TRIG_WIDTH      = 2;
  localparam int c_DEF_MIN_LOW         = 10;
  localparam int c_DEF_TIMEOUT         = 64;

  localparam int c_COUNT_W = 8;
  localparam int c_TIMER_W = 7;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRIG      = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  function automatic logic [c_TIMER_W-1:0] sat_inc(input logic [c_TIMER_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_requester_req_debounce.sv
// ============================================================================
// Module      : req_debounce
// Description : 2-flop synchronizer followed by a consecutive-high debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_debounce
  import reset_requester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      // Any low sample drops the level and restarts the run of highs.
      if (!r_sync) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_level <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/reset_requester.sv
// ============================================================================
// Module      : reset_requester
// Description : Issues a reset trigger on a debounced request and validates
//               the returned reset pulse width and completion time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_requester
  import reset_requester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int TRIG_WIDTH      = c_DEF_TRIG_WIDTH,
  parameter int MIN_LOW         = c_DEF_MIN_LOW,
  parameter int TIMEOUT         = c_DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_in,
  input  logic                 rst_n_obs,
  output logic                 trigger,
  output logic                 busy,
  output logic                 done,
  output logic                 err_short,
  output logic                 err_timeout,
  output logic [c_COUNT_W-1:0] reset_count
);

  localparam int c_TW_W = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;
  localparam logic [c_TW_W-1:0]    c_TRIG_LAST  = c_TW_W'(TRIG_WIDTH - 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

  logic                 w_req_deb;
  logic                 r_req_q;
  logic                 r_obs_meta;
  logic                 r_obs_sync;
  state_t               r_state;
  logic [c_TW_W-1:0]    r_trig_cnt;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] r_low_cnt;
  logic                 r_trigger;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err_short;
  logic                 r_err_timeout;
  logic [c_COUNT_W-1:0] r_reset_count;

  req_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_req_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_async (req_in),
    .o_level (w_req_deb)
  );

  // Reset-released level of the observed reset is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_obs_meta <= 1'b1;
      r_obs_sync <= 1'b1;
    end else begin
      r_obs_meta <= rst_n_obs;
      r_obs_sync <= r_obs_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_req_q       <= 1'b0;
      r_trig_cnt    <= '0;
      r_timer       <= '0;
      r_low_cnt     <= '0;
      r_trigger     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_reset_count <= '0;
    end else begin
      r_req_q       <= w_req_deb;
      r_done        <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        // Only a fresh rising edge starts a sequence; held requests are ignored.
        S_IDLE: begin
          if (w_req_deb && !r_req_q) begin
            r_state    <= S_TRIG;
            r_trigger  <= 1'b1;
            r_busy     <= 1'b1;
            r_trig_cnt <= '0;
          end
        end
        S_TRIG: begin
          if (r_trig_cnt == c_TRIG_LAST) begin
            r_trigger <= 1'b0;
            r_state   <= S_WAIT_LOW;
            r_timer   <= '0;
          end else begin
            r_trig_cnt <= r_trig_cnt + 1'b1;
          end
        end
        S_WAIT_LOW: begin
          if (r_timer == c_TIMER_LAST) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= sat_inc(r_timer);
            if (!r_obs_sync) begin
              r_state   <= S_WAIT_HIGH;
              r_low_cnt <= c_TIMER_W'(1);
            end
          end
        end
        // Completion is tested before the timeout so it wins a tie.
        S_WAIT_HIGH: begin
          if (r_obs_sync) begin
            if (int'(r_low_cnt) >= MIN_LOW) begin
              r_done        <= 1'b1;
              r_reset_count <= r_reset_count + 1'b1;
            end else begin
              r_err_short <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_timer == c_TIMER_LAST) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_timer   <= sat_inc(r_timer);
            r_low_cnt <= sat_inc(r_low_cnt);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_trigger <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign trigger     = r_trigger;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_short   = r_err_short;
  assign err_timeout = r_err_timeout;
  assign reset_count = r_reset_count;

endmodule

`default_nettype wire
